hilo_muldiv_unit: RTL and testbench

//  Iterative signed multiply/divide unit with the architectural Hi/Lo registers, in EXE beside the ALU.

---
 rtl/hilo_muldiv_pkg.sv | 20 ++
 rtl/muldiv_iter_step.sv | 35 +++
 rtl/hilo_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit: ALU-control operation
// codes, sequencer states and the latched operation type.
package hilo_muldiv_pkg;

   localparam int         WIDTH_DEFAULT = 32;
   localparam logic [4:0] OP_CODE_MULT  = 5'h0f;
   localparam logic [4:0] OP_CODE_DIV   = 5'h10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   typedef enum logic {
      OP_TYPE_MULT = 1'b0,
      OP_TYPE_DIV  = 1'b1
   } opType_e;

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational radix-2 step on magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. The sequencer merges quotBit_o into bit 0.
module muldiv_iter_step
   import hilo_muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic [2*WIDTH:0]  acc_i,
   input  logic [WIDTH-1:0]  operand_i,
   input  opType_e           opType_i,
   output logic [2*WIDTH:0]  accNext_o,
   output logic              quotBit_o
);

   logic [WIDTH:0] addSum;
   logic [WIDTH:0] shiftRem;
   logic [WIDTH:0] diffRem;

   // Multiply keeps the product in acc[2W-1:0] with a carry slot on top;
   // divide keeps a W+1 bit partial remainder above the dividend/quotient bits.
   always_comb begin
      addSum    = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, operand_i} : '0);
      shiftRem  = acc_i[2*WIDTH-1:WIDTH-1];
      diffRem   = shiftRem - {1'b0, operand_i};
      quotBit_o = 1'b0;
      accNext_o = '0;
      if (opType_i == OP_TYPE_MULT) begin
         accNext_o = {1'b0, addSum, acc_i[WIDTH-1:1]};
      end else begin
         quotBit_o = (shiftRem >= {1'b0, operand_i});
         accNext_o = {(quotBit_o ? diffRem : shiftRem), acc_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative signed multiply/divide unit owning the architectural Hi/Lo
// registers; stalls the pipeline while a result is pending.
module hilo_muldiv_unit
   import hilo_muldiv_pkg::*;
#(
   parameter int         WIDTH   = WIDTH_DEFAULT,
   parameter logic [4:0] OP_MULT = OP_CODE_MULT,
   parameter logic [4:0] OP_DIV  = OP_CODE_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EXE_LoHiWrite,
   input  logic [4:0]       operation,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             EXE_HiRead,
   input  logic             EXE_LoRead,
   output logic [WIDTH-1:0] hilo_data,
   output logic             stall,
   output logic             busy,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [2*WIDTH:0]   acc_q, acc_d, stepAcc;
   logic               stepQuotBit;
   logic [WIDTH-1:0]   operand_q;
   logic               signA_q, signB_q;
   opType_e            opType_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               divZero_q;

   logic               start;
   logic [WIDTH-1:0]   magA, magB;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient, remainder;
   logic [WIDTH-1:0]   fixHi, fixLo;
   logic               signDiff;

   assign start = (state_q == IDLE) && EXE_LoHiWrite &&
                  ((operation == OP_MULT) || (operation == OP_DIV));
   assign magA  = opA[WIDTH-1] ? -opA : opA;
   assign magB  = opB[WIDTH-1] ? -opB : opB;

   muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
      .acc_i     (acc_q),
      .operand_i (operand_q),
      .opType_i  (opType_q),
      .accNext_o (stepAcc),
      .quotBit_o (stepQuotBit)
   );

   assign acc_d = stepAcc | {{(2*WIDTH){1'b0}}, stepQuotBit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (count_q == '0) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      stall     = busy && (EXE_HiRead || EXE_LoRead || EXE_LoHiWrite);
      hilo_data = EXE_HiRead ? hi_q : (EXE_LoRead ? lo_q : '0);
   end

   // Sign correction: the remainder follows the dividend, so a zero divisor
   // naturally returns the original opA in Hi; only Lo needs forcing.
   always_comb begin
      signDiff  = signA_q ^ signB_q;
      product   = signDiff ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
      quotient  = acc_q[WIDTH-1:0];
      remainder = acc_q[2*WIDTH-1:WIDTH];
      fixHi     = product[2*WIDTH-1:WIDTH];
      fixLo     = product[WIDTH-1:0];
      if (opType_q == OP_TYPE_DIV) begin
         fixHi = signA_q ? -remainder : remainder;
         if (operand_q == '0) fixLo = '1;
         else                 fixLo = signDiff ? -quotient : quotient;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         signA_q   <= 1'b0;
         signB_q   <= 1'b0;
         opType_q  <= OP_TYPE_MULT;
         hi_q      <= '0;
         lo_q      <= '0;
         divZero_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               signA_q   <= opA[WIDTH-1];
               signB_q   <= opB[WIDTH-1];
               count_q   <= CNT_W'(WIDTH - 1);
               divZero_q <= 1'b0;
               if (operation == OP_DIV) begin
                  opType_q  <= OP_TYPE_DIV;
                  acc_q     <= {{(WIDTH+1){1'b0}}, magA};
                  operand_q <= magB;
               end else begin
                  opType_q  <= OP_TYPE_MULT;
                  acc_q     <= {{(WIDTH+1){1'b0}}, magB};
                  operand_q <= magA;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               if (count_q != '0) count_q <= count_q - 1'b1;
            end
            FIX: begin
               hi_q      <= fixHi;
               lo_q      <= fixLo;
               divZero_q <= (opType_q == OP_TYPE_DIV) && (operand_q == '0);
            end
            default: ;
         endcase
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = divZero_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus random
// mult/div traffic compared against a plain 64-bit arithmetic reference.
module tb_hilo_muldiv_unit;

   localparam logic [4:0] MULT = 5'h0f;
   localparam logic [4:0] DIV  = 5'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic        EXE_LoHiWrite;
   logic [4:0]  operation;
   logic [31:0] opA, opB;
   logic        EXE_HiRead, EXE_LoRead;
   logic [31:0] hilo_data;
   logic        stall, busy, div_zero;
   logic [31:0] hi, lo;

   int checkCount = 0;
   int failCount  = 0;

   hilo_muldiv_unit dut (
      .clk           (clk),
      .rst           (rst),
      .EXE_LoHiWrite (EXE_LoHiWrite),
      .operation     (operation),
      .opA           (opA),
      .opB           (opB),
      .EXE_HiRead    (EXE_HiRead),
      .EXE_LoRead    (EXE_LoRead),
      .hilo_data     (hilo_data),
      .stall         (stall),
      .busy          (busy),
      .div_zero      (div_zero),
      .hi            (hi),
      .lo            (lo)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: {hi, lo} from signed 64-bit arithmetic (truncating division)
   function automatic logic [63:0] refModel(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!isDiv) begin
         p = sa * sb;
         return p;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Drives a start request for one edge; returns at the negedge of cycle 1
   task automatic applyStimulus(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      EXE_LoHiWrite = 1'b1;
      operation     = opc;
      opA           = a;
      opB           = b;
      @(posedge clk);
      @(negedge clk);
      EXE_LoHiWrite = 1'b0;
   endtask

   // Waits (bounded) for busy to drop and checks latency and the results
   task automatic finishAndCheck(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input int startCycle);
      int cycles;
      logic [63:0] expVal;
      cycles = startCycle;
      while (busy === 1'b1 && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, "_idle_cycle"}, 64'(cycles), 64'd34);
      expVal = refModel(opc == DIV, a, b);
      checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, expVal[63:32]});
      checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, expVal[31:0]});
      checkOutput({tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, (opc == DIV) && (b == 32'd0)});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int stallBad;
      logic [4:0]  rOp;
      logic [31:0] rA, rB, a1, b1, a2, b2;

      rst = 1'b1; EXE_LoHiWrite = 1'b0; operation = 5'd0; opA = '0; opB = '0;
      EXE_HiRead = 1'b0; EXE_LoRead = 1'b0;
      #1;
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_hi", {32'd0, hi}, 64'd0);
      checkOutput("reset_lo", {32'd0, lo}, 64'd0);
      checkOutput("reset_div_zero", {63'd0, div_zero}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Non mult/div operation with write strobe must be ignored
      @(negedge clk);
      EXE_LoHiWrite = 1'b1; operation = 5'h03; opA = 32'd5; opB = 32'd6;
      @(posedge clk); @(negedge clk);
      checkOutput("ignored_op_busy", {63'd0, busy}, 64'd0);
      EXE_LoHiWrite = 1'b0;

      $display("[TB] test 1: mult 7 x -3");
      applyStimulus(MULT, 32'd7, -32'sd3);
      checkOutput("t1_busy_cycle1", {63'd0, busy}, 64'd1);
      finishAndCheck(MULT, 32'd7, -32'sd3, "t1", 1);
      checkOutput("t1_lo_const", {32'd0, lo}, 64'hFFFF_FFEB);

      // Read mux: Hi wins when both reads are raised
      EXE_HiRead = 1'b1; EXE_LoRead = 1'b1; #1;
      checkOutput("mux_both", {32'd0, hilo_data}, 64'hFFFF_FFFF);
      EXE_HiRead = 1'b0; #1;
      checkOutput("mux_lo", {32'd0, hilo_data}, 64'hFFFF_FFEB);
      EXE_LoRead = 1'b0; #1;
      checkOutput("mux_none", {32'd0, hilo_data}, 64'd0);

      $display("[TB] test 2: mult 0x80000000 squared");
      applyStimulus(MULT, 32'h8000_0000, 32'h8000_0000);
      finishAndCheck(MULT, 32'h8000_0000, 32'h8000_0000, "t2", 1);
      checkOutput("t2_hi_const", {32'd0, hi}, 64'h4000_0000);

      $display("[TB] test 3: signed divides");
      applyStimulus(DIV, -32'sd7, 32'd2);
      finishAndCheck(DIV, -32'sd7, 32'd2, "t3a", 1);
      checkOutput("t3a_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
      applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      finishAndCheck(DIV, 32'h8000_0000, 32'hFFFF_FFFF, "t3b", 1);
      checkOutput("t3b_lo_const", {32'd0, lo}, 64'h8000_0000);

      $display("[TB] test 4: divide by zero");
      applyStimulus(DIV, 32'd5, 32'd0);
      finishAndCheck(DIV, 32'd5, 32'd0, "t4", 1);
      repeat (3) @(negedge clk);
      checkOutput("t4_div_zero_held", {63'd0, div_zero}, 64'd1);
      applyStimulus(MULT, 32'd3, 32'd4);
      checkOutput("t4_div_zero_cleared", {63'd0, div_zero}, 64'd0);
      finishAndCheck(MULT, 32'd3, 32'd4, "t4m", 1);

      $display("[TB] test 5: mflo stalls during mult 6 x 7");
      applyStimulus(MULT, 32'd6, 32'd7);
      @(negedge clk);
      EXE_LoRead = 1'b1;
      stallBad = 0;
      for (int c = 2; c <= 33; c++) begin
         #1;
         if (stall !== 1'b1) stallBad++;
         @(negedge clk);
      end
      #1;
      checkOutput("t5_stall_held", 64'(stallBad), 64'd0);
      checkOutput("t5_stall_released", {63'd0, stall}, 64'd0);
      checkOutput("t5_hilo_data", {32'd0, hilo_data}, 64'd42);
      EXE_LoRead = 1'b0;
      finishAndCheck(MULT, 32'd6, 32'd7, "t5", 34);

      $display("[TB] start and read in the same idle cycle");
      @(negedge clk);
      EXE_LoHiWrite = 1'b1; operation = MULT; opA = 32'd100; opB = 32'd100; EXE_LoRead = 1'b1;
      #1;
      checkOutput("same_cycle_data", {32'd0, hilo_data}, 64'd42);
      checkOutput("same_cycle_stall", {63'd0, stall}, 64'd0);
      @(posedge clk); @(negedge clk);
      EXE_LoHiWrite = 1'b0; EXE_LoRead = 1'b0;
      checkOutput("same_cycle_accepted", {63'd0, busy}, 64'd1);
      finishAndCheck(MULT, 32'd100, 32'd100, "same_cycle", 1);

      $display("[TB] start held while busy");
      a1 = 32'd1234; b1 = -32'sd56; a2 = -32'sd1000; b2 = 32'd7;
      applyStimulus(MULT, a1, b1);
      EXE_LoHiWrite = 1'b1; operation = DIV; opA = a2; opB = b2;
      #1;
      checkOutput("held_start_stall", {63'd0, stall}, 64'd1);
      finishAndCheck(MULT, a1, b1, "held_first", 1);
      @(negedge clk);
      EXE_LoHiWrite = 1'b0;
      checkOutput("held_start_accepted", {63'd0, busy}, 64'd1);
      finishAndCheck(DIV, a2, b2, "held_second", 1);

      $display("[TB] test 6: reset during a divide");
      applyStimulus(DIV, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      EXE_LoRead = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("t6_busy", {63'd0, busy}, 64'd0);
      checkOutput("t6_hi", {32'd0, hi}, 64'd0);
      checkOutput("t6_lo", {32'd0, lo}, 64'd0);
      checkOutput("t6_stall", {63'd0, stall}, 64'd0);
      @(negedge clk);
      rst = 1'b0; EXE_LoRead = 1'b0;
      applyStimulus(DIV, 32'd9, 32'd4);
      finishAndCheck(DIV, 32'd9, 32'd4, "t6_div", 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 24; i++) begin
         rOp = ($urandom_range(0, 1) == 0) ? MULT : DIV;
         case ($urandom_range(0, 5))
            0:       rA = 32'h8000_0000;
            1:       rA = $urandom_range(0, 200) - 100;
            default: rA = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       rB = 32'd0;
            1:       rB = 32'hFFFF_FFFF;
            2:       rB = $urandom_range(0, 40) - 20;
            default: rB = $urandom;
         endcase
         applyStimulus(rOp, rA, rB);
         finishAndCheck(rOp, rA, rB, $sformatf("rand%0d", i), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
